mmio_button_port: RTL

Memory-mapped, parametrised button/input controller for the 16-bit multicycle CPU. It synchronises and debounces `NUM_BUTTONS` active-low raw inputs, latches press events and raises a maskable interrupt. It serves reads at four consecutive addresses, with the legacy priority code at `BASE_ADDR+3`, so it replaces the hard-wired 0xFFFF button mux. The datapath substitutes `rd_data` for `data_from_mem` whenever `rd_hit` is high.

---
 rtl/mmio_pkg.sv | 19 +
 rtl/button_debouncer.sv | 58 +++++
 rtl/mmio_button_port.sv | 121 ++++++++++++
 3 files changed

// File: rtl/mmio_pkg.sv
// Shared definitions for the memory-mapped button port: register offsets,
// default base address and debounce counter sizing.
package mmio_pkg;

    typedef enum logic [1:0] {
        OFF_LEVEL = 2'd0,
        OFF_EVENT = 2'd1,
        OFF_MASK  = 2'd2,
        OFF_CODE  = 2'd3
    } reg_off_e;

    localparam logic [15:0] DEFAULT_BASE_ADDR = 16'hFFFC;

    // Wide enough to hold DEBOUNCE_CYCLES itself, so a count of 1 still gets a bit.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One input channel: two-flop synchroniser, stability counter and a
// single-cycle pulse on the edge where a press is accepted.
module button_debouncer
    import mmio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_n,
    output logic level,
    output logic rise
);

    localparam int unsigned          CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_sync;
    logic             w_differ;
    logic             w_accept;

    assign w_sync   = ~r_sync2;
    assign w_differ = (w_sync != r_stable);
    assign w_accept = w_differ && (r_cnt == CNT_LAST);

    // Synchroniser resets to the released level so no press is seen out of reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= raw_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (!w_differ) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign level = r_stable;
    assign rise  = w_accept && w_sync;

endmodule

// File: rtl/mmio_button_port.sv
// Memory-mapped button controller: LEVEL/EVENT/MASK/CODE words at four
// consecutive addresses, registered read port and maskable interrupt.
module mmio_button_port
    import mmio_pkg::*;
#(
    parameter int unsigned     WIDTH           = 16,
    parameter int unsigned     NUM_BUTTONS     = 3,
    parameter logic [WIDTH-1:0] BASE_ADDR      = WIDTH'(DEFAULT_BASE_ADDR),
    parameter int unsigned     DEBOUNCE_CYCLES = 50000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] buttons_n,
    input  logic [WIDTH-1:0]       mem_address,
    input  logic                   loading,
    input  logic                   storing,
    input  logic [WIDTH-1:0]       wr_data,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   rd_hit,
    output logic                   irq
);

    logic [NUM_BUTTONS-1:0] w_level;
    logic [NUM_BUTTONS-1:0] w_rise;
    logic [NUM_BUTTONS-1:0] r_event;
    logic [NUM_BUTTONS-1:0] r_mask;
    logic [WIDTH-1:0]       r_rd_data;
    logic                   r_rd_hit;
    logic                   r_irq;

    reg_off_e               w_offset;
    logic                   w_in_range;
    logic                   w_rd_en;
    logic                   w_wr_mask;
    logic                   w_clr_event;
    logic                   w_found;
    logic [WIDTH-1:0]       w_code;
    logic [WIDTH-1:0]       w_rd_word;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk  (clk),
            .reset(reset),
            .raw_n(buttons_n[g]),
            .level(w_level[g]),
            .rise (w_rise[g])
        );
    end

    assign w_in_range  = (mem_address[WIDTH-1:2] == BASE_ADDR[WIDTH-1:2]);
    assign w_offset    = reg_off_e'(mem_address[1:0]);
    assign w_rd_en     = loading && !storing && w_in_range;
    assign w_wr_mask   = storing && w_in_range && (w_offset == OFF_MASK);
    assign w_clr_event = w_rd_en && (w_offset == OFF_EVENT);

    always_comb begin
        w_code  = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            if (!w_found && w_level[i]) begin
                w_code  = WIDTH'(i + 1);
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_word = '0;
        case (w_offset)
            OFF_LEVEL: w_rd_word = WIDTH'(w_level);
            OFF_EVENT: w_rd_word = WIDTH'(r_event);
            OFF_MASK:  w_rd_word = WIDTH'(r_mask);
            OFF_CODE:  w_rd_word = w_code;
            default:   w_rd_word = '0;
        endcase
    end

    // A rise on the clearing edge is OR'd in after the clear, so the new event survives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_event <= '0;
        end else begin
            r_event <= (w_clr_event ? '0 : r_event) | w_rise;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mask <= '0;
        end else if (w_wr_mask) begin
            r_mask <= wr_data[NUM_BUTTONS-1:0];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rd_data <= '0;
            r_rd_hit  <= 1'b0;
        end else if (w_rd_en) begin
            r_rd_data <= w_rd_word;
            r_rd_hit  <= 1'b1;
        end else begin
            r_rd_hit  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |(r_event & r_mask);
        end
    end

    assign rd_data = r_rd_data;
    assign rd_hit  = r_rd_hit;
    assign irq     = r_irq;

endmodule
